// File: rtl/clock_display_scan.sv
// Four-digit seven-segment scanner for an hh:mm clock with synchronised, frame-aligned
// input capture, leading-zero blanking on the hours tens digit, and dashes for invalid values.
module clock_display_scan #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hours,
  input  logic [5:0] minutes,
  input  logic       sec_tick,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DIV   = CLK_HZ / REFRESH_HZ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = ACTIVE_LOW;

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] digit_code(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = 7'h3F;
      4'd1:    code = 7'h06;
      4'd2:    code = 7'h5B;
      4'd3:    code = 7'h4F;
      4'd4:    code = 7'h66;
      4'd5:    code = 7'h6D;
      4'd6:    code = 7'h7D;
      4'd7:    code = 7'h07;
      4'd8:    code = 7'h7F;
      4'd9:    code = 7'h6F;
      default: code = 7'h00;
    endcase
    return code;
  endfunction

  logic [CNT_W-1:0] div_cnt_reg;
  logic [1:0]       idx_reg;
  logic [3:0]       h_sync1_reg, h_sync2_reg, h_hist_reg, shadow_h_reg;
  logic [5:0]       m_sync1_reg, m_sync2_reg, m_hist_reg, shadow_m_reg;
  logic             colon_reg;
  logic [3:0]       an_reg;
  logic [6:0]       seg_reg;
  logic             dp_reg;

  logic digit_adv;
  logic frame_end;

  assign digit_adv = (div_cnt_reg == DIV_LAST);
  assign frame_end = digit_adv && (idx_reg == 2'd3);

  // Scan timing and colon
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_reg <= '0;
      idx_reg     <= 2'd0;
      colon_reg   <= 1'b1;
    end else begin
      if (digit_adv) begin
        div_cnt_reg <= '0;
        idx_reg     <= idx_reg + 2'd1;
      end else begin
        div_cnt_reg <= div_cnt_reg + CNT_W'(1);
      end
      if (sec_tick)
        colon_reg <= ~colon_reg;
    end
  end

  // Shadows only accept a value seen identically on two consecutive cycles, so a
  // synchroniser catching an input mid-transition can never reach the display.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_sync1_reg  <= 4'd12;
      h_sync2_reg  <= 4'd12;
      h_hist_reg   <= 4'd12;
      m_sync1_reg  <= 6'd0;
      m_sync2_reg  <= 6'd0;
      m_hist_reg   <= 6'd0;
      shadow_h_reg <= 4'd12;
      shadow_m_reg <= 6'd0;
    end else begin
      h_sync1_reg <= hours;
      h_sync2_reg <= h_sync1_reg;
      h_hist_reg  <= h_sync2_reg;
      m_sync1_reg <= minutes;
      m_sync2_reg <= m_sync1_reg;
      m_hist_reg  <= m_sync2_reg;
      if (frame_end && (h_sync2_reg == h_hist_reg))
        shadow_h_reg <= h_sync2_reg;
      if (frame_end && (m_sync2_reg == m_hist_reg))
        shadow_m_reg <= m_sync2_reg;
    end
  end

  logic       h_valid, m_valid;
  logic [3:0] m_ones, m_tens, h_ones;
  logic [6:0] seg_hi_next;
  logic [3:0] an_hi_next;
  logic       dp_hi_next;

  assign h_valid = (shadow_h_reg != 4'd0) && (shadow_h_reg <= 4'd12);
  assign m_valid = (shadow_m_reg <= 6'd59);
  assign m_ones  = 4'(shadow_m_reg % 6'd10);
  assign m_tens  = 4'(shadow_m_reg / 6'd10);
  assign h_ones  = shadow_h_reg % 4'd10;

  always_comb begin
    seg_hi_next = SEG_BLANK;
    case (idx_reg)
      2'd0: seg_hi_next = m_valid ? digit_code(m_ones) : SEG_DASH;
      2'd1: seg_hi_next = m_valid ? digit_code(m_tens) : SEG_DASH;
      2'd2: seg_hi_next = h_valid ? digit_code(h_ones) : SEG_DASH;
      2'd3: begin
        if (!h_valid)
          seg_hi_next = SEG_DASH;
        else if (shadow_h_reg >= 4'd10)
          seg_hi_next = digit_code(4'd1);
        else
          seg_hi_next = SEG_BLANK;
      end
      default: seg_hi_next = SEG_BLANK;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_anode
      assign an_hi_next[gi] = (idx_reg == 2'(gi));
    end
  endgenerate

  assign dp_hi_next = (idx_reg == 2'd2) && colon_reg;

  // Polarity is applied here so an, seg and dp switch on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_reg  <= AN_OFF;
      seg_reg <= SEG_OFF;
      dp_reg  <= DP_OFF;
    end else begin
      an_reg  <= ACTIVE_LOW ? ~an_hi_next  : an_hi_next;
      seg_reg <= ACTIVE_LOW ? ~seg_hi_next : seg_hi_next;
      dp_reg  <= ACTIVE_LOW ? ~dp_hi_next  : dp_hi_next;
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = dp_reg;

endmodule

// File: tb/tb_clock_display_scan.sv
// Randomised bench for clock_display_scan: a time-indexed reference model predicts every
// displayed digit, anode and colon from the input history and compares each cycle.
module tb_clock_display_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] hours;
  logic [5:0] minutes;
  logic       sec_tick;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  clock_display_scan #(
    .CLK_HZ(16),
    .REFRESH_HZ(4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hours(hours),
    .minutes(minutes),
    .sec_tick(sec_tick),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: edge number since release, input history, shadows, colon.
  int         e;
  logic [3:0] h_hist [0:4095];
  logic [5:0] m_hist [0:4095];
  int         sh_h, sh_m;
  logic       colon;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  function automatic logic [6:0] code_of(input int d);
    logic [6:0] lut [0:9];
    lut[0] = 7'h3F; lut[1] = 7'h06; lut[2] = 7'h5B; lut[3] = 7'h4F; lut[4] = 7'h66;
    lut[5] = 7'h6D; lut[6] = 7'h7D; lut[7] = 7'h07; lut[8] = 7'h7F; lut[9] = 7'h6F;
    return lut[d];
  endfunction

  // Active-high segment pattern for digit position pos of the time hh:mm.
  function automatic logic [6:0] digit_seg(input int pos, input int h, input int m);
    bit hbad = (h == 0) || (h > 12);
    bit mbad = (m > 59);
    case (pos)
      0: return mbad ? 7'h40 : code_of(m % 10);
      1: return mbad ? 7'h40 : code_of(m / 10);
      2: return hbad ? 7'h40 : code_of(h % 10);
      default: return hbad ? 7'h40 : ((h >= 10) ? code_of(1) : 7'h00);
    endcase
  endfunction

  task automatic model_restart();
    e     = 0;
    sh_h  = 12;
    sh_m  = 0;
    colon = 1'b1;
  endtask

  // One clock: record what the DUT sampled, check outputs, then advance the model.
  task automatic step();
    int   pos;
    logic tk;
    @(posedge clk);
    e++;
    h_hist[e] = hours;
    m_hist[e] = minutes;
    tk = sec_tick;
    #1;
    pos = ((e - 1) % FRAME) / DIV;
    check_eq("an",  16'(an),  16'(~(4'b0001 << pos) & 4'hF));
    check_eq("seg", 16'(seg), 16'(~digit_seg(pos, sh_h, sh_m) & 7'h7F));
    check_eq("dp",  16'(dp),  16'(!((pos == 2) && colon)));
    if (tk)
      colon = ~colon;
    if ((e % FRAME) == 0) begin
      if (h_hist[e-2] == h_hist[e-3]) sh_h = int'(h_hist[e-2]);
      if (m_hist[e-2] == m_hist[e-3]) sh_m = int'(m_hist[e-2]);
    end
  endtask

  initial begin
    reset    = 1'b1;
    hours    = 4'd12;
    minutes  = 6'd0;
    sec_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_an",  16'(an),  16'h000F);
    check_eq("rst_seg", 16'(seg), 16'h007F);
    check_eq("rst_dp",  16'(dp),  16'h0001);
    reset = 1'b0;
    model_restart();

    for (int cyc = 0; cyc < 700; cyc++) begin
      step();
      if (cyc < 40) begin
        hours = 4'd12; minutes = 6'd0;
      end else if (cyc < 80) begin
        hours = 4'd7;  minutes = 6'd5;
      end else if (cyc < 88) begin
        minutes = 6'd0;
      end else if (cyc < 130) begin
        minutes = 6'd59;
      end else if (cyc < 170) begin
        hours = 4'd0;  minutes = 6'd60;
      end else if ($urandom_range(0, 9) == 0) begin
        hours   = 4'($urandom_range(0, 15));
        minutes = 6'($urandom_range(0, 63));
      end
      sec_tick = (cyc > 20) && ($urandom_range(0, 5) == 0);
    end

    // Asynchronous reset landing mid-dwell on digit 2.
    while (!((((e % FRAME) / DIV) == 2) && ((e % DIV) == 1)))
      step();
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_an",  16'(an),  16'h000F);
    check_eq("arst_seg", 16'(seg), 16'h007F);
    check_eq("arst_dp",  16'(dp),  16'h0001);
    hours    = 4'd3;
    minutes  = 6'd47;
    sec_tick = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_restart();

    for (int cyc = 0; cyc < 300; cyc++) begin
      step();
      if (cyc > 60 && $urandom_range(0, 7) == 0) begin
        hours   = 4'($urandom_range(1, 12));
        minutes = 6'($urandom_range(0, 59));
      end
      sec_tick = ($urandom_range(0, 4) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
